// File: rtl/sqrt_sched_pkg.sv
// -----------------------------------------------------------------------------
// sqrt_sched_pkg
// Shared types and defaults for the square-root scheduler.
//   state_e      : scheduler FSM states (IDLE -> RUN -> RESP -> IDLE)
//   DEF_*        : default parameter values for sqrt_scheduler
//   GRANT_W      : requester-index width for the default requester count
//   idx_w()      : index width for an arbitrary count (never less than 1 bit)
// -----------------------------------------------------------------------------
package sqrt_sched_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_RESP = 2'd2
    } state_e;

    localparam int DEF_NUM_REQ     = 4;
    localparam int DEF_DATA_W      = 32;
    localparam int DEF_TIMEOUT_CYC = 256;

    localparam int GRANT_W = $clog2(DEF_NUM_REQ);

    // Width needed to hold values 0..n-1; a single bit when n is 1.
    function automatic int idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin pick: the first asserted request found when
// scanning ptr_i, ptr_i+1, ... wrapping modulo NUM_REQ.
//   req_i  in  NUM_REQ  request vector
//   ptr_i  in  GW       index to start the scan from (highest priority)
//   gnt_o  out NUM_REQ  one-hot grant (zero when no request)
//   idx_o  out GW       binary index of the granted request (0 when none)
//   any_o  out 1        at least one request is asserted
// -----------------------------------------------------------------------------
module rr_arbiter
    import sqrt_sched_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int GW      = idx_w(DEF_NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [GW-1:0]      ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [GW-1:0]      idx_o,
    output logic               any_o
);

    int   pos;
    logic found;

    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment, so no path leaves a value unassigned (no latch).
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        pos   = 0;
        for (int off = 0; off < NUM_REQ; off++) begin
            pos = (int'(ptr_i) + off) % NUM_REQ;
            if (!found && req_i[pos]) begin
                found      = 1'b1;
                gnt_o[pos] = 1'b1;
                idx_o      = GW'(pos);
            end
        end
        any_o = found;
    end

endmodule

// File: rtl/sqrt_scheduler.sv
// -----------------------------------------------------------------------------
// sqrt_scheduler
// Shares one square-root unit between NUM_REQ requesters. A round-robin pick
// is accepted only while the unit is available and not signalling DONE; the
// operand is latched and held on sq_in while START is high. The result (or a
// zero result flagged as a timeout) is returned on the shared response bus to
// the requester that issued it. One operation in flight at a time.
//   clk, rstn        clock, asynchronous active-low reset
//   req_valid/ready  per-requester operand handshake (ready one-hot or zero)
//   req_data         packed operands, requester i at [i*DATA_W +: DATA_W]
//   rsp_valid/ready  per-requester result handshake (valid one-hot or zero)
//   rsp_data/err     shared result bus; err marks a timeout (data = 0)
//   sq_start/sq_in   level START and operand to the unit
//   sq_done/avail/out DONE, AVAILABLE and result from the unit
//   busy             FSM not idle
//   timeout_cnt      saturating count of timed-out operations
// -----------------------------------------------------------------------------
module sqrt_scheduler
    import sqrt_sched_pkg::*;
#(
    parameter int NUM_REQ     = DEF_NUM_REQ,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        rsp_valid,
    input  logic [NUM_REQ-1:0]        rsp_ready,
    output logic [DATA_W-1:0]         rsp_data,
    output logic                      rsp_err,
    output logic                      sq_start,
    output logic [DATA_W-1:0]         sq_in,
    input  logic                      sq_done,
    input  logic                      sq_available,
    input  logic [DATA_W-1:0]         sq_out,
    output logic                      busy,
    output logic [7:0]                timeout_cnt
);

    localparam int GW = idx_w(NUM_REQ);
    localparam int TW = idx_w(TIMEOUT_CYC);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

    state_e              state_q,   state_d;
    logic [GW-1:0]       rr_ptr_q,  rr_ptr_d;
    logic [GW-1:0]       gnt_q,     gnt_d;
    logic [DATA_W-1:0]   sq_in_q,   sq_in_d;
    logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
    logic                rsp_err_q, rsp_err_d;
    logic [TW-1:0]       tmo_q,     tmo_d;
    logic [7:0]          tmo_cnt_q, tmo_cnt_d;

    logic [NUM_REQ-1:0]  arb_gnt;
    logic [GW-1:0]       arb_idx;
    logic                arb_any;
    logic                unit_ok;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .GW      (GW)
    ) u_arb (
        .req_i (req_valid),
        .ptr_i (rr_ptr_q),
        .gnt_o (arb_gnt),
        .idx_o (arb_idx),
        .any_o (arb_any)
    );

    // A stale DONE from the previous operation must clear before a new
    // operand is offered, otherwise it would complete the new op instantly.
    assign unit_ok = sq_available && !sq_done;

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        gnt_d      = gnt_q;
        sq_in_d    = sq_in_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        tmo_d      = tmo_q;
        tmo_cnt_d  = tmo_cnt_q;
        req_ready  = '0;
        rsp_valid  = '0;
        sq_start   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (unit_ok) begin
                    req_ready = arb_gnt;
                end
                // Accept: the granted requester is valid and its ready is high.
                if (unit_ok && arb_any) begin
                    sq_in_d  = req_data[int'(arb_idx)*DATA_W +: DATA_W];
                    gnt_d    = arb_idx;
                    rr_ptr_d = (int'(arb_idx) == NUM_REQ - 1) ? '0 : arb_idx + GW'(1);
                    tmo_d    = '0;
                    state_d  = S_RUN;
                end
            end

            S_RUN: begin
                sq_start = 1'b1;
                tmo_d    = tmo_q + TW'(1);
                // DONE takes priority over a timeout landing in the same cycle.
                if (sq_done) begin
                    rsp_data_d = sq_out;
                    rsp_err_d  = 1'b0;
                    state_d    = S_RESP;
                end else if (tmo_q == TMO_LAST) begin
                    rsp_data_d = '0;
                    rsp_err_d  = 1'b1;
                    if (tmo_cnt_q != 8'hFF) begin
                        tmo_cnt_d = tmo_cnt_q + 8'd1;
                    end
                    state_d    = S_RESP;
                end
            end

            S_RESP: begin
                rsp_valid[gnt_q] = 1'b1;
                if (rsp_ready[gnt_q]) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value regardless of process ordering. All of them are plain
    // flops (no memory arrays), so all are cleared by the async reset; an
    // in-flight operation is simply dropped.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= S_IDLE;
            rr_ptr_q   <= '0;
            gnt_q      <= '0;
            sq_in_q    <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
            tmo_q      <= '0;
            tmo_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            gnt_q      <= gnt_d;
            sq_in_q    <= sq_in_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
            tmo_q      <= tmo_d;
            tmo_cnt_q  <= tmo_cnt_d;
        end
    end

    assign sq_in       = sq_in_q;
    assign rsp_data    = rsp_data_q;
    assign rsp_err     = rsp_err_q;
    assign busy        = (state_q != S_IDLE);
    assign timeout_cnt = tmo_cnt_q;

endmodule

// File: tb/tb_sqrt_scheduler.sv
// -----------------------------------------------------------------------------
// tb_sqrt_scheduler
// Bench for sqrt_scheduler with a behavioural square-root unit (DONE after a
// fixed 5 cycles of START). Accepted operands push their expected result to a
// scoreboard; each response handshake pops and compares it.
// -----------------------------------------------------------------------------
module tb_sqrt_scheduler;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int TO = 8;

    logic            clk = 1'b0;
    logic            rstn;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    rsp_valid;
    logic [N-1:0]    rsp_ready;
    logic [DW-1:0]   rsp_data;
    logic            rsp_err;
    logic            sq_start;
    logic [DW-1:0]   sq_in;
    logic            sq_done;
    logic            sq_available;
    logic [DW-1:0]   sq_out;
    logic            busy;
    logic [7:0]      timeout_cnt;

    always #5 clk = ~clk;

    sqrt_scheduler #(.NUM_REQ(N), .DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_data     (req_data),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_data     (rsp_data),
        .rsp_err      (rsp_err),
        .sq_start     (sq_start),
        .sq_in        (sq_in),
        .sq_done      (sq_done),
        .sq_available (sq_available),
        .sq_out       (sq_out),
        .busy         (busy),
        .timeout_cnt  (timeout_cnt)
    );

    // ---------------- behavioural square-root unit ----------------
    logic       hang;        // never raise DONE
    logic       done_stuck;  // force DONE high
    logic [2:0] m_cnt;
    logic       m_done;

    function automatic logic [31:0] isqrt(input logic [31:0] v);
        logic [31:0] r;
        logic [31:0] t;
        r = '0;
        for (int b = 15; b >= 0; b--) begin
            t = r | (32'd1 << b);
            if ({32'd0, t} * {32'd0, t} <= {32'd0, v}) r = t;
        end
        return r;
    endfunction

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_cnt  <= '0;
            m_done <= 1'b0;
        end else if (!sq_start) begin
            m_cnt  <= '0;
            m_done <= 1'b0;
        end else begin
            if (m_cnt < 3'd4) m_cnt <= m_cnt + 3'd1;
            m_done <= (m_cnt >= 3'd3) && !hang;
        end
    end

    assign sq_done = m_done | done_stuck;
    assign sq_out  = isqrt(sq_in);

    // ---------------- checking infrastructure ----------------
    typedef struct {
        int          idx;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        int          idx;
        logic [31:0] data;
        logic        err;
    } sb_t;

    int          n_checks = 0;
    int          n_errors = 0;
    sb_t         sb[$];
    int          grant_log[$];
    logic [31:0] exp_for [N];
    int          run_cnt = 0;
    int          last_run = 0;
    int          ready_cycles = 0;
    logic [N-1:0] acc;
    logic [N-1:0] hs;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: records grants, pushes expectations on accept, compares on
    // response handshake, and measures how long START stays high.
    always @(negedge clk) begin
        if (!rstn) begin
            run_cnt = 0;
        end else begin
            acc = req_valid & req_ready;
            if (acc != '0) begin
                check("req_ready_onehot", 32'($onehot(acc)), 32'd1);
                for (int i = 0; i < N; i++) begin
                    if (acc[i]) begin
                        grant_log.push_back(i);
                        if (hang) sb.push_back('{i, 32'd0, 1'b1});
                        else      sb.push_back('{i, exp_for[i], 1'b0});
                    end
                end
            end
            if (req_ready != '0) ready_cycles++;
            if (sq_start) run_cnt++;
            else if (run_cnt != 0) begin
                last_run = run_cnt;
                run_cnt  = 0;
            end
            hs = rsp_valid & rsp_ready;
            if (hs != '0) begin
                check("rsp_valid_onehot", 32'($onehot(hs)), 32'd1);
                for (int i = 0; i < N; i++) begin
                    if (hs[i]) begin
                        if (sb.size() == 0) begin
                            check("rsp_without_request", 32'd1, 32'd0);
                        end else begin
                            sb_t e;
                            e = sb.pop_front();
                            check("rsp_idx", 32'(i), 32'(e.idx));
                            check("rsp_data", rsp_data, e.data);
                            check("rsp_err", 32'(rsp_err), 32'(e.err));
                        end
                    end
                end
            end
        end
    end

    // ---------------- driver helpers ----------------
    task automatic set_req(input int i, input logic [31:0] d, input logic [31:0] e);
        req_data[i*DW +: DW] = d;
        exp_for[i]           = e;
    endtask

    task automatic wait_accept(input int i);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < 100 && !ok; c++) begin
            @(negedge clk);
            if (req_valid[i] && req_ready[i]) ok = 1'b1;
        end
        if (!ok) check("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < 200 && !ok; c++) begin
            @(negedge clk);
            if (!busy) ok = 1'b1;
        end
        if (!ok) check("idle_timeout", 32'd0, 32'd1);
    endtask

    task automatic issue(input int i, input logic [31:0] d, input logic [31:0] e);
        @(posedge clk);
        #1;
        set_req(i, d, e);
        req_valid[i] = 1'b1;
        wait_accept(i);
        req_valid[i] = 1'b0;
        wait_idle();
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rstn = 1'b0;
        sb.delete();
        grant_log.delete();
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    vec_t vecs [9];
    int   exp_order [5];
    int   n_acc;
    bit   ok;

    initial begin
        vecs[0] = '{0, 32'd25,  32'd5};
        vecs[1] = '{0, 32'd16,  32'd4};
        vecs[2] = '{1, 32'd81,  32'd9};
        vecs[3] = '{2, 32'd144, 32'd12};
        vecs[4] = '{3, 32'd400, 32'd20};
        vecs[5] = '{1, 32'd0,   32'd0};
        vecs[6] = '{2, 32'd1,   32'd1};
        vecs[7] = '{3, 32'd99,  32'd9};
        vecs[8] = '{0, 32'hFFFF_FFFF, 32'd65535};
        exp_order = '{0, 1, 2, 3, 0};

        rstn         = 1'b0;
        req_valid    = '0;
        req_data     = '0;
        rsp_ready    = '1;
        sq_available = 1'b1;
        hang         = 1'b0;
        done_stuck   = 1'b0;
        for (int i = 0; i < N; i++) exp_for[i] = '0;

        // Reset state
        #12;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_sq_start", 32'(sq_start), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_rsp_data", rsp_data, 32'd0);
        check("rst_timeout_cnt", 32'(timeout_cnt), 32'd0);
        @(posedge clk);
        #1;
        rstn = 1'b1;

        // 1: single request, 25 -> 5, ready for one cycle, START for 5 cycles
        ready_cycles = 0;
        issue(vecs[0].idx, vecs[0].data, vecs[0].exp);
        check("t1_ready_cycles", 32'(ready_cycles), 32'd1);
        check("t1_start_cycles", 32'(last_run), 32'd5);

        // 2: all four valid continuously, round-robin from requester 0
        do_reset();
        for (int v = 1; v <= 4; v++) set_req(vecs[v].idx, vecs[v].data, vecs[v].exp);
        req_valid = '1;
        n_acc = 0;
        for (int c = 0; c < 200 && n_acc < 5; c++) begin
            @(negedge clk);
            if ((req_valid & req_ready) != '0) n_acc++;
        end
        @(posedge clk);
        #1;
        req_valid = '0;
        check("t2_accepts", 32'(n_acc), 32'd5);
        wait_idle();
        check("t2_grant_count", 32'(grant_log.size()), 32'd5);
        for (int k = 0; k < 5 && k < grant_log.size(); k++) begin
            check($sformatf("t2_grant_%0d", k), 32'(grant_log[k]), 32'(exp_order[k]));
        end

        // Table pass: each vector as an isolated operation
        for (int v = 0; v < 9; v++) issue(vecs[v].idx, vecs[v].data, vecs[v].exp);

        // 3: response backpressure on requester 1 while requester 0 waits
        @(posedge clk);
        #1;
        rsp_ready[1] = 1'b0;
        set_req(1, 32'd49, 32'd7);
        req_valid[1] = 1'b1;
        wait_accept(1);
        req_valid[1] = 1'b0;
        set_req(0, 32'd9, 32'd3);
        req_valid[0] = 1'b1;
        ok = 1'b0;
        for (int c = 0; c < 50 && !ok; c++) begin
            @(negedge clk);
            if (rsp_valid[1]) ok = 1'b1;
        end
        check("t3_rsp_seen", 32'(ok), 32'd1);
        for (int k = 0; k < 10; k++) begin
            check("t3_hold_valid", 32'(rsp_valid), 32'h2);
            check("t3_hold_data", rsp_data, 32'd7);
            check("t3_hold_ready", 32'(req_ready), 32'd0);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        rsp_ready[1] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("t3_idle_after_release", 32'(busy), 32'd0);
        check("t3_next_ready", 32'(req_ready), 32'h1);
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
        wait_idle();

        // 4: hung unit times out after TO cycles, then a normal op
        hang = 1'b1;
        issue(2, 32'd64, 32'd8);
        hang = 1'b0;
        check("t4_start_cycles", 32'(last_run), 32'(TO));
        check("t4_timeout_cnt", 32'(timeout_cnt), 32'd1);
        issue(2, 32'd64, 32'd8);
        check("t4_normal_start_cycles", 32'(last_run), 32'd5);
        check("t4_timeout_cnt_stable", 32'(timeout_cnt), 32'd1);

        // 5: unit unavailable, then DONE stuck high: no accept until both clear
        @(posedge clk);
        #1;
        sq_available = 1'b0;
        set_req(3, 32'd36, 32'd6);
        req_valid[3] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("t5_unavail_ready", 32'(req_ready), 32'd0);
            check("t5_unavail_busy", 32'(busy), 32'd0);
        end
        @(posedge clk);
        #1;
        sq_available = 1'b1;
        done_stuck   = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("t5_done_stuck_ready", 32'(req_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        done_stuck = 1'b0;
        @(negedge clk);
        check("t5_release_ready", 32'(req_ready), 32'h8);
        @(posedge clk);
        #1;
        req_valid[3] = 1'b0;
        wait_idle();

        // 6: reset in RUN drops START at once and restarts round-robin at 0
        @(posedge clk);
        #1;
        set_req(2, 32'd100, 32'd10);
        req_valid[2] = 1'b1;
        wait_accept(2);
        req_valid[2] = 1'b0;
        @(negedge clk);
        check("t6_running", 32'(sq_start), 32'd1);
        @(posedge clk);
        #1;
        rstn = 1'b0;
        sb.delete();
        #1;
        check("t6_rst_sq_start", 32'(sq_start), 32'd0);
        check("t6_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("t6_rst_busy", 32'(busy), 32'd0);
        check("t6_rst_timeout_cnt", 32'(timeout_cnt), 32'd0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        set_req(0, 32'd49, 32'd7);
        set_req(2, 32'd4, 32'd2);
        set_req(3, 32'd9, 32'd3);
        req_valid = 4'b1101;
        @(negedge clk);
        check("t6_first_grant", 32'(req_ready), 32'h1);
        @(posedge clk);
        #1;
        req_valid = '0;
        wait_idle();

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
